if_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit pipelined processor: owns the PC register, next-PC selection and the IF/ID pipeline register.
- Sits directly upstream of decode and consumes the hazard controller's pcstall, IF_IDstall and flushIF_ID outputs.
- Also consumes the branch redirect (PCSrc + target) and jump redirect (jump + target).
- Drives a combinational-read instruction memory and presents registered instruction, PC+step and a valid bit to decode.

---
 rtl/if_stage.sv | 145 ++++++++++++++
 tb/tb_if_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 16-bit pipelined processor.
//
// Owns the fetch PC, the next-PC selection and the IF/ID pipeline register.
// The instruction memory is read combinationally at imem_addr (= pcF). The
// word returned in the same cycle is captured into IF/ID, so an instruction
// shows up on instrD one cycle after its address was on pcF.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   pcstall           hold the PC (load-use or branch-flush window)
//   IF_IDstall        hold the IF/ID register
//   flushIF_ID        load a bubble (NOP_INSTR, validD=0) into IF/ID
//   PCSrc, branch_target  taken-branch redirect and destination
//   jump, jump_target     jump redirect from decode and destination
//   imem_addr         instruction-memory address (same value as pcF)
//   imem_rdata        instruction word, valid in the same cycle
//   pcF               current fetch PC
//   instrD            registered instruction to decode
//   pcplusD           registered pcF + PC_STEP
//   validD            IF/ID holds a real instruction
//
// Optional build macro IF_PERF_CNT_EN adds three saturating counters:
//   stall_cycles      cycles with pcstall=1 and no redirect
//   bubble_cycles     cycles in which IF/ID loads a flush bubble
//   redirect_cnt      cycles with PCSrc or jump
// All three clear on rst.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned                ADDR_WIDTH  = 16,
    parameter int unsigned                INSTR_WIDTH = 16,
    parameter int unsigned                PC_STEP     = 1,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pcstall,
    input  logic                   IF_IDstall,
    input  logic                   flushIF_ID,
    input  logic                   PCSrc,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   jump,
    input  logic [ADDR_WIDTH-1:0]  jump_target,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0]  pcF,
    output logic [INSTR_WIDTH-1:0] instrD,
    output logic [ADDR_WIDTH-1:0]  pcplusD,
    output logic                   validD
`ifdef IF_PERF_CNT_EN
    ,
    output logic [ADDR_WIDTH-1:0]  stall_cycles,
    output logic [ADDR_WIDTH-1:0]  bubble_cycles,
    output logic [ADDR_WIDTH-1:0]  redirect_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LP_STEP = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0]  r_pcplus;
    logic                   r_valid;

    logic [ADDR_WIDTH-1:0]  w_pc_plus;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic                   w_redirect;

    // Modulo-2^ADDR_WIDTH increment; the wrap past all-ones is intentional.
    assign w_pc_plus  = r_pc + LP_STEP;
    assign w_redirect = PCSrc | jump;

    // Redirects sit above pcstall: the hazard controller raises pcstall in
    // the same cycle as a taken branch and the target must still be loaded.
    // A branch beats a simultaneous jump.
    always_comb begin
        w_pc_next = w_pc_plus;
        if (PCSrc)
            w_pc_next = branch_target;
        else if (jump)
            w_pc_next = jump_target;
        else if (pcstall)
            w_pc_next = r_pc;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_next;
    end

    // IF/ID register. Flush beats stall so that a flush arriving during a
    // stall window still turns the slot into a bubble. pcstall also freezes
    // IF/ID, otherwise the same fetched word would be captured twice.
    always_ff @(posedge clk) begin
        if (rst || flushIF_ID) begin
            r_instr  <= NOP_INSTR;
            r_pcplus <= '0;
            r_valid  <= 1'b0;
        end else if (IF_IDstall || pcstall) begin
            r_instr  <= r_instr;
            r_pcplus <= r_pcplus;
            r_valid  <= r_valid;
        end else begin
            r_instr  <= imem_rdata;
            r_pcplus <= w_pc_plus;
            r_valid  <= 1'b1;
        end
    end

    assign imem_addr = r_pc;
    assign pcF       = r_pc;
    assign instrD    = r_instr;
    assign pcplusD   = r_pcplus;
    assign validD    = r_valid;

`ifdef IF_PERF_CNT_EN
    logic [ADDR_WIDTH-1:0] r_stall_cnt;
    logic [ADDR_WIDTH-1:0] r_bubble_cnt;
    logic [ADDR_WIDTH-1:0] r_redir_cnt;

    // Each counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_redir_cnt  <= '0;
        end else begin
            if (pcstall && !w_redirect && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flushIF_ID && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (w_redirect && (r_redir_cnt != '1))
                r_redir_cnt <= r_redir_cnt + 1'b1;
        end
    end

    assign stall_cycles  = r_stall_cnt;
    assign bubble_cycles = r_bubble_cnt;
    assign redirect_cnt  = r_redir_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// The driver applies one cycle of stimulus at the falling edge, advances a
// reference model of the fetch stage and queues the state it expects after
// the next rising edge. A monitor samples 1 ns after every rising edge and
// compares the DUT against the oldest queued entry.
// The instruction memory returns 16'hA000 + address.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam int AW = 16;
    localparam int IW = 16;
    localparam logic [IW-1:0] NOP = 16'h0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          pcstall = 1'b0, IF_IDstall = 1'b0, flushIF_ID = 1'b0;
    logic          PCSrc = 1'b0, jump = 1'b0;
    logic [AW-1:0] branch_target = '0, jump_target = '0;
    logic [AW-1:0] imem_addr, pcF, pcplusD;
    logic [IW-1:0] imem_rdata, instrD;
    logic          validD;
`ifdef IF_PERF_CNT_EN
    logic [AW-1:0] stall_cycles, bubble_cycles, redirect_cnt;
`endif

    assign imem_rdata = 16'hA000 + imem_addr;

    if_stage dut (
        .clk(clk), .rst(rst), .pcstall(pcstall), .IF_IDstall(IF_IDstall),
        .flushIF_ID(flushIF_ID), .PCSrc(PCSrc), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pcF(pcF), .instrD(instrD),
        .pcplusD(pcplusD), .validD(validD)
`ifdef IF_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles),
        .redirect_cnt(redirect_cnt)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
        logic [AW-1:0] pcplus;
        logic          valid;
        logic [AW-1:0] stall_c;
        logic [AW-1:0] bubble_c;
        logic [AW-1:0] redir_c;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;            // model of the architectural state after each edge
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        return (v == {AW{1'b1}}) ? v : v + 16'd1;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic ps, input logic is,
                         input logic fl, input logic bs,
                         input logic [AW-1:0] bt, input logic j,
                         input logic [AW-1:0] jt);
        exp_t n;
        @(negedge clk);
        rst = r; pcstall = ps; IF_IDstall = is; flushIF_ID = fl;
        PCSrc = bs; branch_target = bt; jump = j; jump_target = jt;

        n = m;
        // where does fetch go next
        if (r)        n.pc = 16'h0000;
        else if (bs)  n.pc = bt;
        else if (j)   n.pc = jt;
        else if (ps)  n.pc = m.pc;
        else          n.pc = m.pc + 16'd1;
        // what decode sees next
        if (r || fl) begin
            n.instr = NOP; n.pcplus = 16'h0000; n.valid = 1'b0;
        end else if (!(is || ps)) begin
            n.instr = 16'hA000 + m.pc; n.pcplus = m.pc + 16'd1; n.valid = 1'b1;
        end
        // event counters
        if (r) begin
            n.stall_c = '0; n.bubble_c = '0; n.redir_c = '0;
        end else begin
            if (ps && !bs && !j) n.stall_c  = sat_inc(m.stall_c);
            if (fl)              n.bubble_c = sat_inc(m.bubble_c);
            if (bs || j)         n.redir_c  = sat_inc(m.redir_c);
        end
        m = n;
        exp_q.push_back(n);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, '0, 0, '0);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pcF",       32'(pcF),       32'(e.pc));
            chk("imem_addr", 32'(imem_addr), 32'(e.pc));
            chk("instrD",    32'(instrD),    32'(e.instr));
            chk("pcplusD",   32'(pcplusD),   32'(e.pcplus));
            chk("validD",    32'(validD),    32'(e.valid));
`ifdef IF_PERF_CNT_EN
            chk("stall_cycles",  32'(stall_cycles),  32'(e.stall_c));
            chk("bubble_cycles", 32'(bubble_cycles), 32'(e.bubble_c));
            chk("redirect_cnt",  32'(redirect_cnt),  32'(e.redir_c));
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m = '0;
        // reset, then free-run: pcF 0..4, instrD NOP,A000..A003
        drive(1, 0, 0, 0, 0, '0, 0, '0);
        drive(1, 0, 0, 0, 0, '0, 0, '0);
        idle(5);                                     // pcF -> 5
        // load-use stall for one cycle at pcF=5
        drive(0, 1, 0, 0, 0, '0, 0, '0);
        idle(3);                                     // pcF -> 8
        // branch to 0x40 with a 3-cycle flush window
        drive(0, 1, 0, 1, 1, 16'h0040, 0, '0);
        repeat (3) drive(0, 1, 0, 1, 0, '0, 0, '0);
        idle(2);
        // jump to 0x100 with one-cycle flush
        drive(0, 0, 0, 1, 0, '0, 1, 16'h0100);
        idle(2);
        // branch and jump together: branch wins
        drive(0, 0, 0, 0, 1, 16'h0020, 1, 16'h0030);
        idle(1);
        // IF_IDstall alone, then flush together with stall
        drive(0, 0, 1, 0, 0, '0, 0, '0);
        drive(0, 1, 1, 1, 0, '0, 0, '0);
        idle(1);
        // wrap from 0xFFFF
        drive(0, 0, 0, 1, 0, '0, 1, 16'hFFFF);
        idle(3);
        // reset inside a branch flush window
        drive(0, 1, 0, 1, 1, 16'h0200, 0, '0);
        drive(0, 1, 0, 1, 0, '0, 0, '0);
        drive(1, 1, 0, 1, 0, '0, 0, '0);
        idle(3);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r, ps, is, fl, bs, j;
            r  = ($urandom_range(0, 49) == 0);
            ps = ($urandom_range(0, 4) == 0);
            is = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 7) == 0);
            drive(r, ps, is, fl, bs, 16'($urandom_range(0, 65535)), j,
                  16'($urandom_range(0, 65535)));
        end
        idle(2);

        // drain: every queued expectation must have been consumed
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
